arb_req_mux: RTL and testbench

//  Requester-side companion to a round-robin grant arbiter: collects WIDTH valid/ready source

---
 rtl/arb_req_mux.sv | 128 ++++++++++++
 tb/tb_arb_req_mux.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/arb_req_mux.sv
// arb_req_mux: requester-side companion to an external round-robin arbiter.
// Collects WIDTH valid/ready sources, presents requests as v_vld, consumes the
// one-hot v_grant and muxes the granted beat into a 2-entry output FIFO.
// Optional packet lock (sources cannot interleave mid-packet): define ARB_LOCK_EN.
module arb_req_mux #(
    parameter  int WIDTH = 4,
    parameter  int DW    = 32,
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    s_vld,
    output logic [WIDTH-1:0]    s_rdy,
    input  logic [WIDTH*DW-1:0] s_data,
    input  logic [WIDTH-1:0]    s_last,
    output logic [WIDTH-1:0]    v_vld,
    input  logic [WIDTH-1:0]    v_grant,
    output logic                m_vld,
    input  logic                m_rdy,
    output logic [DW-1:0]       m_data,
    output logic [SW-1:0]       m_src,
    output logic                m_last,
    output logic                err
);
    logic             w_can_acc;
    logic [WIDTH-1:0] w_req_mask;
    logic             w_grant_multi;
    logic             w_grant_stray;
    logic             w_push;
    logic             w_pop;
    logic [SW-1:0]    w_src;
    logic [DW-1:0]    w_data;
    logic             w_last;
    logic [1:0]       r_count;
    logic             r_wp;
    logic             r_rp;
    logic [DW-1:0]    r_data [2];
    logic [SW-1:0]    r_src  [2];
    logic [1:0]       r_last;
    logic             r_err;

    // Requests are only raised when the granted beat can be stored this cycle,
    // because the arbiter rotates its priority on every non-zero request vector.
    assign w_can_acc     = rst_n && (r_count != 2'd2);
    assign v_vld         = w_can_acc ? (s_vld & w_req_mask) : '0;
    assign w_grant_multi = |(v_grant & (v_grant - WIDTH'(1)));
    assign w_grant_stray = |(v_grant & ~v_vld);
    // A multi-hot grant transfers nothing; a stray grant bit is masked by v_vld.
    assign s_rdy         = w_grant_multi ? '0 : (v_grant & v_vld);
    assign w_push        = |s_rdy;
    assign w_pop         = m_vld & m_rdy;

    // Select data/index/last of the single source that transfers this cycle.
    always_comb begin
        w_src  = '0;
        w_data = '0;
        w_last = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s_rdy[i]) begin
                w_src  = SW'(i);
                w_data = s_data[i*DW +: DW];
                w_last = s_last[i];
            end
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide for full throughput.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_wp    <= 1'b0;
            r_rp    <= 1'b0;
        end else begin
            if (w_push) r_wp <= ~r_wp;
            if (w_pop) r_rp <= ~r_rp;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // FIFO storage; contents are only observed through m_vld-gated outputs.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wp] <= w_data;
            r_src[r_wp]  <= w_src;
            r_last[r_wp] <= w_last;
        end
    end

    assign m_vld  = (r_count != 2'd0);
    assign m_data = m_vld ? r_data[r_rp] : '0;
    assign m_src  = m_vld ? r_src[r_rp]  : '0;
    assign m_last = m_vld ? r_last[r_rp] : 1'b0;

    // Sticky flag for a grant that is multi-hot or points at a non-requester.
    always_ff @(posedge clk) begin
        if (!rst_n) r_err <= 1'b0;
        else if (w_grant_multi || w_grant_stray) r_err <= 1'b1;
    end

    assign err = r_err;

`ifdef ARB_LOCK_EN
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]    r_state;
    logic [SW-1:0] r_lock_src;

    // Lock onto the source of a non-final beat until that source sends its last beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_lock_src <= '0;
        end else if (w_push) begin
            if (r_state == ST_IDLE && !w_last) begin
                r_state    <= ST_LOCKED;
                r_lock_src <= w_src;
            end else if (r_state == ST_LOCKED && w_last && w_src == r_lock_src) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign w_req_mask = (r_state == ST_LOCKED) ? (WIDTH'(1) << r_lock_src) : '1;
`else
    assign w_req_mask = '1;
`endif
endmodule

// File: tb/tb_arb_req_mux.sv
// tb_arb_req_mux: directed bench with a round-robin arbiter model driving v_grant.
module tb_arb_req_mux;
    localparam int WIDTH = 4;
    localparam int DW    = 32;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] s_vld;
    logic [WIDTH-1:0] s_rdy;
    logic [WIDTH*DW-1:0] s_data;
    logic [WIDTH-1:0] s_last;
    logic [WIDTH-1:0] v_vld;
    logic [WIDTH-1:0] v_grant;
    logic             m_vld;
    logic             m_rdy;
    logic [DW-1:0]    m_data;
    logic [1:0]       m_src;
    logic             m_last;
    logic             err;

    logic             force_en;
    logic [WIDTH-1:0] force_g;
    logic [WIDTH-1:0] rr_grant;
    logic [1:0]       ptr;
    int               n_vec;
    int               n_bad;

    arb_req_mux #(.WIDTH(WIDTH), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .s_vld(s_vld), .s_rdy(s_rdy), .s_data(s_data),
        .s_last(s_last), .v_vld(v_vld), .v_grant(v_grant), .m_vld(m_vld), .m_rdy(m_rdy),
        .m_data(m_data), .m_src(m_src), .m_last(m_last), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round-robin arbiter: first requester at or after ptr wins.
    always_comb begin
        rr_grant = '0;
        for (int k = 0; k < WIDTH; k++)
            if (rr_grant == '0 && v_vld[2'(ptr + 2'(k))]) rr_grant[2'(ptr + 2'(k))] = 1'b1;
    end

    assign v_grant = force_en ? force_g : rr_grant;

    // Priority moves past the winner on every granted request.
    always @(posedge clk) begin
        if (!rst_n) ptr <= 2'd0;
        else if (!force_en)
            for (int k = 0; k < WIDTH; k++)
                if (rr_grant[k]) ptr <= 2'(k + 1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic setd(input int i, input logic [DW-1:0] v);
        s_data[i*DW +: DW] = v;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        force_en = 1'b0;
        force_g  = '0;
        rst_n    = 1'b0;
        s_vld    = 4'hF;
        s_last   = '0;
        m_rdy    = 1'b1;
        for (int i = 0; i < WIDTH; i++) setd(i, 32'hA0 + 32'(i));

        // Reset held two cycles with all sources valid
        tick();
        tick();
        chk("rst_v_vld", 64'(v_vld), 64'h0);
        chk("rst_s_rdy", 64'(s_rdy), 64'h0);
        chk("rst_m_vld", 64'(m_vld), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_m_data", 64'(m_data), 64'h0);

        // Streaming round-robin at one beat per cycle
        rst_n = 1'b1;
        settle();
        chk("rr_v_vld", 64'(v_vld), 64'hF);
        chk("rr_s_rdy0", 64'(s_rdy), 64'h1);
        chk("rr_m_vld_pre", 64'(m_vld), 64'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_m_vld", 64'(m_vld), 64'h1);
            chk("rr_m_src", 64'(m_src), 64'(k % 4));
            chk("rr_m_data", 64'(m_data), 64'(32'hA0 + 32'(k % 4)));
        end

        // Drain, then back-pressure a single source
        s_vld = 4'h0;
        tick();
        chk("drain_m_vld", 64'(m_vld), 64'h0);
        m_rdy = 1'b0;
        s_vld = 4'b0001;
        setd(0, 32'hB0);
        settle();
        chk("bp_v_vld", 64'(v_vld), 64'h1);
        chk("bp_s_rdy", 64'(s_rdy), 64'h1);
        tick();
        setd(0, 32'hB1);
        tick();
        setd(0, 32'hB2);
        chk("full_v_vld", 64'(v_vld), 64'h0);
        chk("full_s_rdy", 64'(s_rdy), 64'h0);
        chk("full_m_vld", 64'(m_vld), 64'h1);
        chk("full_m_data", 64'(m_data), 64'hB0);
        tick();
        chk("hold_m_data", 64'(m_data), 64'hB0);
        chk("hold_m_src", 64'(m_src), 64'h0);
        m_rdy = 1'b1;
        settle();
        chk("rel_v_vld", 64'(v_vld), 64'h0);
        tick();
        chk("rel_m_data1", 64'(m_data), 64'hB1);
        chk("rel_v_vld1", 64'(v_vld), 64'h1);
        tick();
        setd(0, 32'hB3);
        chk("rel_m_data2", 64'(m_data), 64'hB2);
        tick();
        setd(0, 32'hB4);
        chk("rel_m_data3", 64'(m_data), 64'hB3);

        // Multi-hot grant: no transfer, sticky error until reset
        s_vld    = 4'b0011;
        force_en = 1'b1;
        force_g  = 4'b0011;
        settle();
        chk("bad_v_vld", 64'(v_vld), 64'h3);
        chk("bad_s_rdy", 64'(s_rdy), 64'h0);
        tick();
        chk("bad_err", 64'(err), 64'h1);
        chk("bad_m_vld", 64'(m_vld), 64'h0);
        force_en = 1'b0;
        s_vld    = 4'h0;
        tick();
        chk("bad_err_sticky", 64'(err), 64'h1);
        rst_n = 1'b0;
        tick();
        chk("bad_err_clr", 64'(err), 64'h0);
        rst_n = 1'b1;

        // Source 2 sends a 3-beat packet, source 0 joins from beat 2
        s_vld = 4'b0100;
        setd(2, 32'hC0);
        setd(0, 32'hD0);
        s_last = 4'b0000;
        tick();
        chk("pk1_m_src", 64'(m_src), 64'h2);
        chk("pk1_m_data", 64'(m_data), 64'hC0);
        chk("pk1_m_last", 64'(m_last), 64'h0);
        s_vld = 4'b0101;
        setd(2, 32'hC1);
`ifdef ARB_LOCK_EN
        settle();
        chk("lk2_v_vld", 64'(v_vld), 64'h4);
        tick();
        chk("lk2_m_src", 64'(m_src), 64'h2);
        chk("lk2_m_data", 64'(m_data), 64'hC1);
        setd(2, 32'hC2);
        s_last = 4'b0100;
        settle();
        chk("lk3_v_vld", 64'(v_vld), 64'h4);
        tick();
        chk("lk3_m_src", 64'(m_src), 64'h2);
        chk("lk3_m_last", 64'(m_last), 64'h1);
        s_vld  = 4'b0001;
        s_last = 4'b0000;
        settle();
        chk("lk4_v_vld", 64'(v_vld), 64'h1);
        tick();
        chk("lk4_m_src", 64'(m_src), 64'h0);
        chk("lk4_m_data", 64'(m_data), 64'hD0);
        chk("lk4_m_last", 64'(m_last), 64'h0);
`else
        settle();
        chk("il2_v_vld", 64'(v_vld), 64'h5);
        chk("il2_s_rdy", 64'(s_rdy), 64'h1);
        tick();
        chk("il2_m_src", 64'(m_src), 64'h0);
        chk("il2_m_data", 64'(m_data), 64'hD0);
        setd(0, 32'hD1);
        settle();
        chk("il3_s_rdy", 64'(s_rdy), 64'h4);
        tick();
        chk("il3_m_src", 64'(m_src), 64'h2);
        chk("il3_m_data", 64'(m_data), 64'hC1);
        chk("il3_m_last", 64'(m_last), 64'h0);
        setd(2, 32'hC2);
        s_last = 4'b0100;
        settle();
        chk("il4_s_rdy", 64'(s_rdy), 64'h1);
        tick();
        chk("il4_m_src", 64'(m_src), 64'h0);
        chk("il4_m_data", 64'(m_data), 64'hD1);
        chk("il4_m_last", 64'(m_last), 64'h0);
        setd(0, 32'hD2);
        settle();
        chk("il5_s_rdy", 64'(s_rdy), 64'h4);
        tick();
        chk("il5_m_src", 64'(m_src), 64'h2);
        chk("il5_m_data", 64'(m_data), 64'hC2);
        chk("il5_m_last", 64'(m_last), 64'h1);
        s_vld  = 4'b0001;
        s_last = 4'b0000;
        tick();
        chk("il6_m_src", 64'(m_src), 64'h0);
        chk("il6_m_data", 64'(m_data), 64'hD2);
        chk("il6_m_last", 64'(m_last), 64'h0);
`endif
        s_vld = 4'h0;
        tick();
        chk("end_m_vld", 64'(m_vld), 64'h0);
        chk("end_err", 64'(err), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
